// File: rtl/pf_tile_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : pf_tile_fetch
//  Description : Playfield tile fetch sequencer. Addresses the playfield RAM
//                read port one 4-tile group ahead of the beam, captures the
//                32-bit word, and serialises its four tile bytes one per
//                8-pixel column together with the tile row.
//  Revision    : 1.0 - initial release
// ============================================================================
module pf_tile_fetch (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_ce,
  input  logic [7:0]  h,
  input  logic [7:0]  v,
  input  logic        hblank,
  input  logic        vblank,
  input  logic        flip,
  output logic [7:0]  pf_addr,
  output logic [3:0]  pf_ce_n,
  input  logic [31:0] pf_data,
  output logic [7:0]  tile_code,
  output logic [2:0]  tile_row,
  output logic        tile_valid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    READ = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  pf_addr_q, pf_addr_d;
  logic [3:0]  pf_ce_n_q, pf_ce_n_d;
  logic [31:0] prefetch_q, prefetch_d;
  logic [31:0] shift_q, shift_d;
  logic [2:0]  tile_row_q, tile_row_d;
  logic        tile_valid_q, tile_valid_d;

  logic        load_shift;
  logic [2:0]  grp_next;
  logic [2:0]  grp_sel;
  logic [4:0]  row_sel;
  logic [31:0] prefetch_rev;

  // Next group wraps mod 8 within the same tile row; flip mirrors both axes.
  assign grp_next     = h[7:5] + 3'd1;
  assign grp_sel      = flip ? ~grp_next : grp_next;
  assign row_sel      = flip ? ~v[7:3]   : v[7:3];
  assign prefetch_rev = {prefetch_q[7:0], prefetch_q[15:8],
                         prefetch_q[23:16], prefetch_q[31:24]};

  // State and datapath registers; reset dominates everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      pf_addr_q    <= 8'h00;
      pf_ce_n_q    <= 4'b1111;
      prefetch_q   <= 32'h0;
      shift_q      <= 32'h0;
      tile_row_q   <= 3'd0;
      tile_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pf_addr_q    <= pf_addr_d;
      pf_ce_n_q    <= pf_ce_n_d;
      prefetch_q   <= prefetch_d;
      shift_q      <= shift_d;
      tile_row_q   <= tile_row_d;
      tile_valid_q <= tile_valid_d;
    end
  end

  // Fetch FSM: address at h=28, capture at h=29, hand over to serialiser at h=31.
  // vblank aborts any fetch immediately, without waiting for pix_ce.
  always_comb begin
    state_d    = state_q;
    pf_addr_d  = pf_addr_q;
    pf_ce_n_d  = pf_ce_n_q;
    prefetch_d = prefetch_q;
    load_shift = 1'b0;
    if (vblank) begin
      state_d   = IDLE;
      pf_ce_n_d = 4'b1111;
    end else if (pix_ce) begin
      case (state_q)
        IDLE: begin
          if (h[4:0] == 5'd28) begin
            state_d   = ADDR;
            pf_addr_d = {row_sel, grp_sel};
            pf_ce_n_d = 4'b0000;
          end
        end
        ADDR: begin
          state_d    = READ;
          prefetch_d = pf_data;
          pf_ce_n_d  = 4'b1111;
        end
        READ: begin
          state_d = HOLD;
        end
        HOLD: begin
          if (h[4:0] == 5'd31) begin
            state_d    = IDLE;
            load_shift = 1'b1;
          end
        end
        default: begin
          state_d   = IDLE;
          pf_ce_n_d = 4'b1111;
        end
      endcase
    end
  end

  // Serialiser and per-pixel line info; the shifter freezes during vblank.
  always_comb begin
    shift_d      = shift_q;
    tile_row_d   = tile_row_q;
    tile_valid_d = tile_valid_q;
    if (pix_ce) begin
      tile_row_d   = flip ? ~v[2:0] : v[2:0];
      tile_valid_d = ~hblank & ~vblank;
      if (!vblank) begin
        if (load_shift) begin
          shift_d = flip ? prefetch_rev : prefetch_q;
        end else if ((h[2:0] == 3'd7) && (h[4:0] != 5'd31)) begin
          shift_d = shift_q >> 8;
        end
      end
    end
  end

  assign pf_addr    = pf_addr_q;
  assign pf_ce_n    = pf_ce_n_q;
  assign tile_code  = shift_q[7:0];
  assign tile_row   = tile_row_q;
  assign tile_valid = tile_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_pf_tile_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pf_tile_fetch
//  Description : Directed self-checking bench for pf_tile_fetch with a
//                combinational RAM model on the read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pf_tile_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pix_ce = 1'b0;
  logic [7:0]  h = 8'h00;
  logic [7:0]  v = 8'h00;
  logic        hblank = 1'b0;
  logic        vblank = 1'b0;
  logic        flip = 1'b0;
  logic [7:0]  pf_addr;
  logic [3:0]  pf_ce_n;
  logic [31:0] pf_data;
  logic [7:0]  tile_code;
  logic [2:0]  tile_row;
  logic        tile_valid;

  logic [31:0] mem [256];
  int checks = 0;
  int errors = 0;

  pf_tile_fetch dut (
    .clk        (clk),
    .reset      (reset),
    .pix_ce     (pix_ce),
    .h          (h),
    .v          (v),
    .hblank     (hblank),
    .vblank     (vblank),
    .flip       (flip),
    .pf_addr    (pf_addr),
    .pf_ce_n    (pf_ce_n),
    .pf_data    (pf_data),
    .tile_code  (tile_code),
    .tile_row   (tile_row),
    .tile_valid (tile_valid)
  );

  always #5 clk = ~clk;

  // RAM model: each byte lane drives data only while its bank is enabled.
  always_comb begin
    pf_data = 32'h0;
    for (int n = 0; n < 4; n++) begin
      pf_data[8*n +: 8] = pf_ce_n[n] ? 8'h00 : mem[pf_addr][8*n +: 8];
    end
  end

  task automatic clk_step(input logic ce);
    pix_ce = ce;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; pix_ce = 1'b1; h = 8'd28; v = 8'h07; flip = 1'b0;
    hblank = 1'b0; vblank = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (pf_ce_n !== 4'b1111) begin errors++; $display("FAIL reset_ce_n got %b want 1111", pf_ce_n); end
    checks++; if (pf_addr !== 8'h00) begin errors++; $display("FAIL reset_addr got %h want 00", pf_addr); end
    checks++; if (tile_code !== 8'h00) begin errors++; $display("FAIL reset_tile_code got %h want 00", tile_code); end
    checks++; if (tile_valid !== 1'b0) begin errors++; $display("FAIL reset_tile_valid got %b want 0", tile_valid); end
    checks++; if (tile_row !== 3'd0) begin errors++; $display("FAIL reset_tile_row got %0d want 0", tile_row); end
    reset = 1'b0;
    // First pix_ce after reset at h=29 must not see a fetch already in flight.
    h = 8'd29;
    clk_step(1'b1);
    checks++; if (pf_ce_n !== 4'b1111) begin errors++; $display("FAIL reset_idle_ce_n got %b want 1111", pf_ce_n); end
  endtask

  task automatic test_normal;
    logic [7:0] e;
    flip = 1'b0; v = 8'h28;
    for (int hh = 0; hh < 64; hh++) begin
      h = 8'(hh);
      clk_step(1'b1);
      checks++;
      if (pf_ce_n !== (((hh == 28) || (hh == 60)) ? 4'b0000 : 4'b1111)) begin
        errors++; $display("FAIL normal_ce_n h=%0d got %b", hh, pf_ce_n);
      end
      if (hh == 28) begin
        checks++; if (pf_addr !== 8'h29) begin errors++; $display("FAIL normal_addr got %h want 29", pf_addr); end
      end
      if (hh >= 31 && hh <= 62) begin
        e = 8'(32'h44332211 >> (8 * ((hh - 31) / 8)));
        checks++;
        if (tile_code !== e) begin errors++; $display("FAIL normal_tile h=%0d got %h want %h", hh, tile_code, e); end
      end
    end
    checks++; if (tile_row !== 3'd0) begin errors++; $display("FAIL normal_row got %0d want 0", tile_row); end
    checks++; if (tile_valid !== 1'b1) begin errors++; $display("FAIL normal_valid got %b want 1", tile_valid); end
  endtask

  task automatic test_wrap;
    flip = 1'b0; v = 8'h05;
    for (int hh = 248; hh < 256; hh++) begin
      h = 8'(hh);
      clk_step(1'b1);
      if (hh == 252) begin
        checks++; if (pf_addr !== 8'h00) begin errors++; $display("FAIL wrap_addr got %h want 00", pf_addr); end
        checks++; if (pf_ce_n !== 4'b0000) begin errors++; $display("FAIL wrap_ce_n got %b want 0000", pf_ce_n); end
      end
    end
    checks++; if (tile_code !== 8'hA1) begin errors++; $display("FAIL wrap_tile got %h want a1", tile_code); end
    checks++; if (tile_row !== 3'd5) begin errors++; $display("FAIL wrap_row got %0d want 5", tile_row); end
  endtask

  task automatic test_flip;
    logic [7:0] e;
    flip = 1'b1; v = 8'h28;
    for (int hh = 0; hh < 64; hh++) begin
      h = 8'(hh);
      clk_step(1'b1);
      if (hh == 28) begin
        checks++; if (pf_addr !== 8'hD6) begin errors++; $display("FAIL flip_addr got %h want d6", pf_addr); end
      end
      if (hh == 60) begin
        checks++; if (pf_addr !== 8'hD5) begin errors++; $display("FAIL flip_addr2 got %h want d5", pf_addr); end
      end
      if (hh >= 31 && hh <= 62) begin
        e = 8'(32'h44332211 >> (8 * (3 - (hh - 31) / 8)));
        checks++;
        if (tile_code !== e) begin errors++; $display("FAIL flip_tile h=%0d got %h want %h", hh, tile_code, e); end
      end
    end
    checks++; if (tile_row !== 3'd7) begin errors++; $display("FAIL flip_row got %0d want 7", tile_row); end
    flip = 1'b0;
  endtask

  task automatic test_vblank_abort;
    reset = 1'b1; clk_step(1'b0); reset = 1'b0;
    flip = 1'b0; v = 8'h28; vblank = 1'b0;
    for (int hh = 0; hh <= 28; hh++) begin
      h = 8'(hh);
      clk_step(1'b1);
    end
    checks++; if (pf_ce_n !== 4'b0000) begin errors++; $display("FAIL abort_pre_ce_n got %b want 0000", pf_ce_n); end
    // Abort on a clock with no pixel enable.
    vblank = 1'b1; h = 8'd29;
    clk_step(1'b0);
    checks++; if (pf_ce_n !== 4'b1111) begin errors++; $display("FAIL abort_ce_n got %b want 1111", pf_ce_n); end
    checks++; if (dut.prefetch_q !== 32'h0) begin errors++; $display("FAIL abort_prefetch got %h want 0", dut.prefetch_q); end
    checks++; if (tile_valid !== 1'b1) begin errors++; $display("FAIL abort_valid_hold got %b want 1", tile_valid); end
    clk_step(1'b1);
    checks++; if (tile_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %b want 0", tile_valid); end
    checks++; if (pf_ce_n !== 4'b1111) begin errors++; $display("FAIL abort_ce_n2 got %b want 1111", pf_ce_n); end
    vblank = 1'b0;
    for (int hh = 30; hh < 64; hh++) begin
      h = 8'(hh);
      clk_step(1'b1);
      if (hh == 31) begin
        checks++; if (tile_code !== 8'h00) begin errors++; $display("FAIL abort_tile got %h want 00", tile_code); end
      end
      if (hh == 60) begin
        checks++; if (pf_addr !== 8'h2A) begin errors++; $display("FAIL abort_refetch_addr got %h want 2a", pf_addr); end
      end
    end
    checks++; if (tile_code !== 8'h5E) begin errors++; $display("FAIL abort_refetch_tile got %h want 5e", tile_code); end
  endtask

  task automatic test_throttle;
    logic [7:0] e;
    int lows;
    lows = 0;
    reset = 1'b1; clk_step(1'b0); reset = 1'b0;
    flip = 1'b0; v = 8'h28; vblank = 1'b0; hblank = 1'b0;
    for (int hh = 0; hh < 64; hh++) begin
      h = 8'(hh);
      for (int k = 0; k < 4; k++) begin
        clk_step(k == 0);
        if (hh < 32 && pf_ce_n == 4'b0000) lows++;
        checks++;
        if (pf_ce_n !== (((hh == 28) || (hh == 60)) ? 4'b0000 : 4'b1111)) begin
          errors++; $display("FAIL throttle_ce_n h=%0d k=%0d got %b", hh, k, pf_ce_n);
        end
        if (hh >= 31 && hh <= 62) begin
          e = 8'(32'h44332211 >> (8 * ((hh - 31) / 8)));
          checks++;
          if (tile_code !== e) begin errors++; $display("FAIL throttle_tile h=%0d k=%0d got %h want %h", hh, k, tile_code, e); end
        end
      end
      if (hh == 28) begin
        checks++; if (pf_addr !== 8'h29) begin errors++; $display("FAIL throttle_addr got %h want 29", pf_addr); end
      end
    end
    checks++; if (lows !== 4) begin errors++; $display("FAIL throttle_low_clks got %0d want 4", lows); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {8'(i), 8'(i ^ 8'hA5), 8'(i + 3), 8'(~i)};
    mem[8'h29] = 32'h44332211;
    mem[8'hD6] = 32'h44332211;
    mem[8'h00] = 32'h998877A1;
    mem[8'h08] = 32'h1234567B;
    mem[8'h2A] = 32'hCAFEBA5E;
    test_reset();
    test_normal();
    test_wrap();
    test_flip();
    test_vblank_abort();
    test_throttle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
